// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell is reused once per bit, LSB first,
// through a registered carry. Result is presented with a one-cycle done pulse.

module sc2_block (
  output logic s_out,
  output logic c_out,
  input  logic a_in,
  input  logic b_in,
  input  logic c_in
);
  assign s_out = a_in ^ b_in ^ c_in;
  assign c_out = (a_in & b_in) | (c_in & (a_in ^ b_in));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s_out,
  output logic             c_out
);
  // One extra counter bit so WIDTH=1 and power-of-two widths reach LAST without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADD  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;

  sc2_block u_fa (
    .s_out (fa_s),
    .c_out (fa_c),
    .a_in  (a_sr[0]),
    .b_in  (b_sr[0]),
    .c_in  (carry)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 lands at sum_sr[0].
  always_comb begin
    sum_next            = sum_sr >> 1;
    sum_next[WIDTH-1]   = fa_s;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      s_out  <= '0;
      c_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            a_sr   <= a_in;
            b_sr   <= b_in;
            carry  <= c_in;
            cnt    <= '0;
            sum_sr <= '0;
            busy   <= 1'b1;
            state  <= ADD;
          end
        end
        ADD: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_next;
          carry  <= fa_c;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            s_out <= sum_next;
            c_out <= fa_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
